// File: rtl/btn_step_gen_if.sv
// Button front-end signal bundle: raw button and repeat control in, step strobe and
// debounced level out.
interface btn_step_gen_if;
  logic btn_in;
  logic repeat_en;
  logic step;
  logic level;

  modport master (
    output btn_in,
    output repeat_en,
    input  step,
    input  level
  );

  modport slave (
    input  btn_in,
    input  repeat_en,
    output step,
    output level
  );
endinterface

// File: rtl/btn_step_gen.sv
// Debounced push-button to single-cycle step strobe, with optional auto-repeat while held.
// Feeds the enable of the downstream 4-bit counter; all outputs are registered.
module btn_step_gen #(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned HOLD_CYCLES   = 16,
  parameter int unsigned REPEAT_CYCLES = 8,
  parameter int unsigned CW            = 8
) (
  input  logic           clk,
  input  logic           reset,
  btn_step_gen_if.slave  bus
);

  typedef enum logic [2:0] {
    StIdle,
    StPressChk,
    StHeld,
    StRepeat,
    StRelChk
  } state_e;

  localparam logic [CW-1:0] TimerZero  = '0;
  localparam logic [CW-1:0] TimerOne   = CW'(1);
  localparam logic [CW-1:0] StableLast = CW'(STABLE_CYCLES - 1);
  localparam logic [CW-1:0] HoldLast   = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] RepeatLast = CW'(REPEAT_CYCLES - 1);

  state_e        r_state;
  logic [CW-1:0] r_timer;
  logic          r_sync1;
  logic          r_btn_s;
  logic          r_step;
  logic          r_level;

  // Timer holds the number of qualifying samples already seen in the current state.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= StIdle;
      r_timer <= TimerZero;
      r_sync1 <= 1'b0;
      r_btn_s <= 1'b0;
      r_step  <= 1'b0;
      r_level <= 1'b0;
    end else begin
      r_sync1 <= bus.btn_in;
      r_btn_s <= r_sync1;
      r_step  <= 1'b0;
      case (r_state)
        StIdle: begin
          if (r_btn_s) begin
            r_state <= StPressChk;
            r_timer <= TimerOne;
          end
        end
        StPressChk: begin
          if (!r_btn_s) begin
            r_state <= StIdle;
            r_timer <= TimerZero;
          end else if (r_timer == StableLast) begin
            r_state <= StHeld;
            r_step  <= 1'b1;
            r_level <= 1'b1;
            r_timer <= TimerZero;
          end else begin
            r_timer <= r_timer + TimerOne;
          end
        end
        StHeld: begin
          if (!r_btn_s) begin
            r_state <= StRelChk;
            r_timer <= TimerOne;
          end else if (r_timer == HoldLast) begin
            // Saturate here until repeat is enabled; then fire on the next held sample.
            if (bus.repeat_en) begin
              r_state <= StRepeat;
              r_step  <= 1'b1;
              r_timer <= TimerZero;
            end
          end else begin
            r_timer <= r_timer + TimerOne;
          end
        end
        StRepeat: begin
          if (!r_btn_s) begin
            r_state <= StRelChk;
            r_timer <= TimerOne;
          end else if (!bus.repeat_en) begin
            r_state <= StHeld;
            r_timer <= TimerZero;
          end else if (r_timer == RepeatLast) begin
            r_step  <= 1'b1;
            r_timer <= TimerZero;
          end else begin
            r_timer <= r_timer + TimerOne;
          end
        end
        StRelChk: begin
          if (r_btn_s) begin
            r_state <= StHeld;
            r_timer <= TimerZero;
          end else if (r_timer == StableLast) begin
            r_state <= StIdle;
            r_level <= 1'b0;
            r_timer <= TimerZero;
          end else begin
            r_timer <= r_timer + TimerOne;
          end
        end
        default: begin
          r_state <= StIdle;
          r_timer <= TimerZero;
          r_level <= 1'b0;
        end
      endcase
    end
  end

  assign bus.step  = r_step;
  assign bus.level = r_level;

endmodule

// File: tb/tb_btn_step_gen.sv
// Bench for btn_step_gen: directed timing scenarios plus randomized button traffic, all
// checked cycle by cycle against a run-length reference model.
module tb_btn_step_gen;

  localparam int Stable = 4;
  localparam int Hold   = 16;
  localparam int Rep    = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  btn_step_gen_if bus ();

  btn_step_gen #(
    .STABLE_CYCLES(Stable),
    .HOLD_CYCLES  (Hold),
    .REPEAT_CYCLES(Rep),
    .CW           (8)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int n_total = 0;
  int n_bad   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: synchroniser pipe, then run lengths of high/low samples.
  bit m_s1, m_s2, m_lvl, m_step, m_rep;
  int m_hi, m_lo, m_since;

  task automatic model_edge(input bit b, input bit r, input bit rs);
    bit s;
    s = m_s2;
    if (rs) begin
      m_s1 = 0; m_s2 = 0; m_lvl = 0; m_step = 0; m_rep = 0;
      m_hi = 0; m_lo = 0; m_since = 0;
      return;
    end
    m_s2   = m_s1;
    m_s1   = b;
    m_step = 0;
    if (!m_lvl) begin
      m_hi = s ? m_hi + 1 : 0;
      if (m_hi == Stable) begin
        m_lvl = 1; m_step = 1; m_hi = 0; m_lo = 0; m_since = 0; m_rep = 0;
      end
    end else if (!s) begin
      m_lo++;
      m_since = 0;
      m_rep   = 0;
      if (m_lo == Stable) begin
        m_lvl = 0;
        m_lo  = 0;
      end
    end else if (m_lo != 0) begin
      m_lo = 0;
    end else if (m_rep && !r) begin
      m_rep   = 0;
      m_since = 0;
    end else begin
      m_since++;
      if (r && m_since >= (m_rep ? Rep : Hold)) begin
        m_step  = 1;
        m_since = 0;
        m_rep   = 1;
      end
    end
  endtask

  int edge_idx;
  int q[$];
  int lvl_rise;
  int lvl_fall;

  task automatic start_test();
    edge_idx = 0;
    q.delete();
    lvl_rise = -1;
    lvl_fall = -1;
  endtask

  task automatic cyc(input bit b, input bit r, input bit rs);
    bus.btn_in    = b;
    bus.repeat_en = r;
    reset         = rs;
    @(posedge clk);
    model_edge(b, r, rs);
    #1;
    check_val("step", 32'(bus.step), 32'(m_step));
    check_val("level", 32'(bus.level), 32'(m_lvl));
    if (bus.step === 1'b1) q.push_back(edge_idx);
    if (bus.level === 1'b1 && lvl_rise < 0) lvl_rise = edge_idx;
    if (bus.level === 1'b0 && lvl_rise >= 0 && lvl_fall < 0) lvl_fall = edge_idx;
    edge_idx++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0);
  endtask

  task automatic check_edges(input string tag, input int n, input int e0, input int e1,
                             input int e2, input int e3);
    int exp_e[4];
    exp_e = '{e0, e1, e2, e3};
    check_val({tag, "_count"}, 32'(q.size()), 32'(n));
    for (int i = 0; i < n && i < q.size(); i++)
      check_val($sformatf("%s_edge%0d", tag, i), 32'(q[i]), 32'(exp_e[i]));
  endtask

  initial begin
    int len;
    bit b, rs, ren;
    bit bounce[7];

    bus.btn_in    = 1'b0;
    bus.repeat_en = 1'b0;
    reset         = 1'b1;

    // Reset with toggling button, then quiet release
    start_test();
    cyc(1'b1, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b1);
    idle(20);
    check_edges("reset", 0, 0, 0, 0, 0);
    check_val("reset_level_rise", 32'(lvl_rise), -32'sd1);

    // Clean press, no repeat
    start_test();
    for (int i = 0; i < 10; i++) cyc(1'b1, 1'b0, 1'b0);
    idle(12);
    check_edges("clean", 1, 5, 0, 0, 0);
    check_val("clean_level_rise", 32'(lvl_rise), 32'd5);
    check_val("clean_level_fall", 32'(lvl_fall), 32'd15);

    // Bounce rejection
    start_test();
    bounce = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 7; i++) cyc(bounce[i], 1'b0, 1'b0);
    idle(10);
    check_edges("bounce", 0, 0, 0, 0, 0);
    check_val("bounce_level", 32'(lvl_rise), -32'sd1);

    // Auto-repeat hold, then same hold without repeat
    start_test();
    for (int i = 0; i < 40; i++) cyc(1'b1, 1'b1, 1'b0);
    check_edges("repeat", 4, 5, 21, 29, 37);
    idle(12);
    start_test();
    for (int i = 0; i < 40; i++) cyc(1'b1, 1'b0, 1'b0);
    check_edges("norepeat", 1, 5, 0, 0, 0);
    idle(12);

    // Release glitch restarts the hold delay
    start_test();
    for (int i = 0; i < 10; i++) cyc(1'b1, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 30; i++) cyc(1'b1, 1'b1, 1'b0);
    check_edges("glitch", 3, 5, 30, 38, 0);
    check_val("glitch_level_fall", 32'(lvl_fall), -32'sd1);
    idle(12);

    // Reset in the middle of an auto-repeat hold
    start_test();
    for (int i = 0; i < 20; i++) cyc(1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b1);
    cyc(1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 14; i++) cyc(1'b1, 1'b1, 1'b0);
    check_edges("midreset", 2, 5, 27, 0, 0);
    check_val("midreset_level_fall", 32'(lvl_fall), 32'd20);
    idle(12);

    // Randomized runs with bounces, repeat toggles and occasional reset
    ren = 1'b0;
    for (int k = 0; k < 220; k++) begin
      len = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : $urandom_range(1, 30);
      b   = 1'($urandom_range(0, 1));
      rs  = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 5) == 0) ren = ~ren;
      for (int j = 0; j < len; j++) cyc(b, ren, rs && (j < 2));
    end
    idle(12);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/btn_step_gen.md
# btn_step_gen

Debounced push-button front end that produces the single-cycle `enable` strobe for the 4-bit up-counter stage. A raw, asynchronous, bouncy button input is synchronised, qualified for stability, and converted into one `step` pulse per accepted press. An optional auto-repeat mode emits further pulses while the button stays held. `step` connects directly to the counter's `enable`; both blocks share `clk` and `reset`.

## Interface
- `STABLE_CYCLES`, 4: consecutive identical synchronised samples required to accept a press or a release (≥2).
- `HOLD_CYCLES`, 16: held samples after acceptance before the first auto-repeat pulse (≥2).
- `REPEAT_CYCLES`, 8: held samples between later auto-repeat pulses (≥2).
- `CW`, 8: timer width; max(parameters) ≤ 2^CW−1.

- `clk`  in  1  single clock, rising edge
- `reset`  in  1  synchronous, active-high; one clock, reset is synchronous and active-high
- `btn_in`  in  1  raw button, asynchronous to `clk`, may bounce
- `repeat_en`  in  1  synchronous; 1 = auto-repeat while held
- `step`  out  1  registered one-cycle pulse per accepted press or repeat; drives the counter's `enable`
- `level`  out  1  registered debounced button state

## Operation
- Two-flop synchroniser: `btn_in` → `sync1` → `btn_s`. Only `btn_s` is used downstream of the synchroniser.
- `timer` (CW bits) counts qualifying samples. FSM states:
  - IDLE (`level`=0): `btn_s`=1 → PRESS_CHK, timer=1.
  - PRESS_CHK: `btn_s`=0 → IDLE, timer=0. Otherwise, once the STABLE_CYCLES-th consecutive high sample is reached → HELD, `step`=1, `level`=1, timer=0. Otherwise timer+1.
  - HELD (`level`=1): `btn_s`=0 → REL_CHK, timer=1. If `repeat_en`=1 and the HOLD_CYCLES-th consecutive high sample is reached → REPEAT, `step`=1, timer=0. With `repeat_en`=0, timer saturates at HOLD_CYCLES−1 and no pulse is emitted.
  - REPEAT (`level`=1): `btn_s`=0 → REL_CHK, timer=1. `repeat_en`=0 → HELD, timer=0. On the REPEAT_CYCLES-th high sample, `step`=1 and timer=0.
  - REL_CHK (`level`=1): `btn_s`=1 → HELD, timer=0, so the hold delay restarts. On the STABLE_CYCLES-th consecutive low sample → IDLE, `level`=0. No pulse on release.
- `step` is the default 0 every cycle and is high for exactly one cycle per event. It never asserts in consecutive cycles.
- Reset (synchronous, priority over everything):
  - At the edge where `reset`=1: `sync1`, `btn_s`, `timer`, `step` and `level` all go to 0, and the state goes to IDLE.
  - Reset asserted mid-press discards all progress.
  - A button held through reset release is re-qualified from scratch and yields exactly one fresh `step`.

## Timing
- Edge numbering: edge 0 is the first rising edge that samples `btn_in`=1.
  - `btn_s` goes high after edge 1.
  - The press is accepted at edge 1+STABLE_CYCLES.
  - `step` and `level` are high in the cycle following that edge.
  - With defaults, `step` is high between edges 5 and 6.
- Release uses the same numbering: first low sample at edge R gives `level`=0 after edge R+1+STABLE_CYCLES.
- Auto-repeat pulses come HOLD_CYCLES edges after the press `step`, then every REPEAT_CYCLES edges. With defaults: edges 5, 21, 29, 37, …
- `repeat_en` changes take effect at the next edge. No combinational path exists from any input to any output.

## Test plan
- **Reset:** `reset`=1 for 2 cycles while `btn_in` toggles → `step`=0 and `level`=0 throughout. Release reset with `btn_in`=0 → outputs stay 0 for 20 cycles.
- **Clean press:** `btn_in`=1 sampled at edges 0–9, then 0 (`repeat_en`=0) → `step` high only between edges 5 and 6; `level` rises after edge 5 and falls after edge 15. Downstream count = 1.
- **Bounce rejection:** `btn_in` pattern 1,1,1,0,1,1,0 then 0 → no `step`, `level` stays 0, count unchanged.
- **Auto-repeat:** `repeat_en`=1, `btn_in`=1 sampled at edges 0–39 → `step` after edges 5, 21, 29, 37 only (4 pulses); downstream count = 4. Same hold with `repeat_en`=0 → single pulse after edge 5.
- **Release glitch:** held press, then 2 low samples, then high again → no extra `step`, `level` stays 1, hold timer restarts (repeat delay measured from the glitch end).
- **Reset mid-press:** auto-repeat hold, `reset`=1 at edges 20–21, button still held → no pulse at edge 21; `level`=0 after edge 20; next `step` after edge 27 (first post-reset sample at edge 22).
